prol16_mem_slave: RTL and testbench

- Synthesizable memory-bus responder on the downstream side of the PROL16 CPU memory interface.
- Serves CPU reads and writes driven on the active-low strobes ce/oe/we.
- Preloads a program image through a valid/ready loader port and releases the CPU only when loading is done.
- Freezes on halt or illegal instruction and exposes a dump read port so the bench can compare memory against the model.

---
 rtl/prol16_mem_slave_pkg.sv | 47 ++++
 rtl/prol16_dp_ram.sv | 60 ++++++
 rtl/prol16_mem_slave.sv | 216 +++++++++++++++++++++
 tb/tb_prol16_mem_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prol16_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prol16_mem_slave_pkg
// Description : Shared definitions for the PROL16 memory-bus responder:
//               bus/word width, responder state encoding and the decoded
//               CPU strobe operation, plus the strobe decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package prol16_mem_slave_pkg;

    // Bus and word width of the PROL16 core (gDataWidth).
    localparam int G_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2,
        OP_ERR  = 2'd3
    } bus_op_t;

    // Active-low strobes. ce high means idle regardless of oe/we; oe and we
    // both low is a protocol error; ce low with neither oe nor we is idle.
    function automatic bus_op_t decode_strobes(input logic ce_n,
                                               input logic oe_n,
                                               input logic we_n);
        bus_op_t op;
        op = OP_IDLE;
        if (!ce_n) begin
            if (!oe_n && !we_n) begin
                op = OP_ERR;
            end else if (!oe_n) begin
                op = OP_RD;
            end else if (!we_n) begin
                op = OP_WR;
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prol16_dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : prol16_dp_ram
// Description : Word RAM with one write port and two registered read ports.
//               The CPU read port is write-first; the dump port reads the
//               contents present before the edge. Array contents are not
//               reset; only the read output registers are.
// Ports       : clk, rst_n         clock, async active-low reset
//               i_we/i_waddr/i_wdata     shared write port
//               i_rd_en/i_raddr/o_rdata  CPU read port (holds when idle)
//               i_dump_addr/o_dump_data  dump read port (every cycle)
// Revision    : 1.0  initial release
// ============================================================================
module prol16_dp_ram
    import prol16_mem_slave_pkg::*;
#(
    parameter int DATA_WIDTH = G_DATA_WIDTH,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic [ADDR_BITS-1:0]  i_dump_addr,
    output logic [DATA_WIDTH-1:0] o_dump_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_dump_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata     <= '0;
            r_dump_data <= '0;
        end else begin
            if (i_rd_en) begin
                r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
            end
            r_dump_data <= r_mem[i_dump_addr];
        end
    end

    assign o_rdata     = r_rdata;
    assign o_dump_data = r_dump_data;

endmodule
`default_nettype wire

// File: rtl/prol16_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : prol16_mem_slave
// Description : Memory responder for the PROL16 CPU bus. Preloads a program
//               image through a valid/ready loader, then enables the CPU and
//               serves reads/writes on active-low strobes until halt or
//               illegal instruction, after which memory and counters freeze.
// Ports       : clk, rst_n                       clock, async active-low reset
//               load_valid_i/ready_o/data_i/last_i  program loader
//               cpu_en_o                         CPU run enable
//               mem_addr_i, mem_data_i/o, mem_ce_ni/oe_ni/we_ni  CPU bus
//               cpu_halt_i, illegal_inst_i       stop indications
//               halted_o, illegal_o, bus_err_o, load_ovf_o  status
//               dump_addr_i, dump_data_o         second read port
//               rd_cnt_o, wr_cnt_o               accepted access counters
// Options     : PROL16_MEM_STATS_EN - implements the access counters; when
//               undefined both counter outputs are constant zero.
// Revision    : 1.0  initial release
// ============================================================================
module prol16_mem_slave
    import prol16_mem_slave_pkg::*;
#(
    parameter int DATA_WIDTH = G_DATA_WIDTH,
    parameter int ADDR_BITS  = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    output logic                  cpu_en_o,
    input  logic [DATA_WIDTH-1:0] mem_addr_i,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ce_ni,
    input  logic                  mem_oe_ni,
    input  logic                  mem_we_ni,
    input  logic                  cpu_halt_i,
    input  logic                  illegal_inst_i,
    output logic                  halted_o,
    output logic                  illegal_o,
    output logic                  bus_err_o,
    output logic                  load_ovf_o,
    input  logic [ADDR_BITS-1:0]  dump_addr_i,
    output logic [DATA_WIDTH-1:0] dump_data_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    localparam logic [ADDR_BITS-1:0] c_ptr_one = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_BITS-1:0]  r_ptr;
    logic                  r_illegal;
    logic                  r_bus_err;
    logic                  r_load_ovf;
    logic                  r_rd_oor;

    logic                  w_load_ready;
    logic                  w_cpu_en;
    logic                  w_halted;
    logic                  w_ld_acc;
    logic                  w_ptr_full;
    logic                  w_run;
    bus_op_t               w_op;
    logic                  w_oor;
    logic                  w_cpu_wr;
    logic                  w_cpu_rd;
    logic                  w_ram_we;
    logic [ADDR_BITS-1:0]  w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Address range check: any set bit above the implemented range.
    generate
        if (ADDR_BITS < DATA_WIDTH) begin : g_oor
            assign w_oor = |mem_addr_i[DATA_WIDTH-1:ADDR_BITS];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_op       = decode_strobes(mem_ce_ni, mem_oe_ni, mem_we_ni);
    assign w_run      = (r_state == ST_RUN);
    assign w_ld_acc   = load_valid_i && (r_state == ST_LOAD);
    assign w_ptr_full = (r_ptr == {ADDR_BITS{1'b1}});
    assign w_cpu_wr   = w_run && (w_op == OP_WR) && !w_oor;
    assign w_cpu_rd   = w_run && (w_op == OP_RD);

    // Loader and CPU never write in the same cycle: they belong to
    // different states, so a plain mux suffices.
    assign w_ram_we    = w_ld_acc || w_cpu_wr;
    assign w_ram_waddr = w_ld_acc ? r_ptr : mem_addr_i[ADDR_BITS-1:0];
    assign w_ram_wdata = w_ld_acc ? load_data_i : mem_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_cpu_en     = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (w_ld_acc && (load_last_i || w_ptr_full)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cpu_en = 1'b1;
                if (cpu_halt_i || illegal_inst_i) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_load_ovf <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            if (w_ld_acc) begin
                r_ptr <= r_ptr + c_ptr_one;
            end
            if (w_ld_acc && w_ptr_full && !load_last_i) begin
                r_load_ovf <= 1'b1;
            end
            if (w_run && ((w_op == OP_ERR) ||
                          (((w_op == OP_RD) || (w_op == OP_WR)) && w_oor))) begin
                r_bus_err <= 1'b1;
            end
            if (w_run && illegal_inst_i) begin
                r_illegal <= 1'b1;
            end
            // Remembers whether the latest read was out of range so the
            // held read data shows zero instead of the RAM register.
            if (w_cpu_rd) begin
                r_rd_oor <= w_oor;
            end
        end
    end

    prol16_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_ram_we),
        .i_waddr     (w_ram_waddr),
        .i_wdata     (w_ram_wdata),
        .i_rd_en     (w_cpu_rd && !w_oor),
        .i_raddr     (mem_addr_i[ADDR_BITS-1:0]),
        .o_rdata     (w_ram_rdata),
        .i_dump_addr (dump_addr_i),
        .o_dump_data (dump_data_o)
    );

`ifdef PROL16_MEM_STATS_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] r_wr_cnt;

    // Out-of-range accesses still count; protocol errors do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_run && (w_op == OP_RD) && (r_rd_cnt != {CNT_WIDTH{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + c_cnt_one;
            end
            if (w_run && (w_op == OP_WR) && (r_wr_cnt != {CNT_WIDTH{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + c_cnt_one;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`else
    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
`endif

    assign load_ready_o = w_load_ready;
    assign cpu_en_o     = w_cpu_en;
    assign halted_o     = w_halted;
    assign illegal_o    = r_illegal;
    assign bus_err_o    = r_bus_err;
    assign load_ovf_o   = r_load_ovf;
    assign mem_data_o   = r_rd_oor ? '0 : w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_prol16_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_prol16_mem_slave
// Description : Self-checking bench for prol16_mem_slave. A behavioural
//               model (plain arrays and counters) tracks state, memory and
//               flags; a compare process checks every output each cycle.
//               Directed test-plan steps add literal expectations, then
//               randomized CPU traffic and a loader overflow run follow.
//               Honours PROL16_MEM_STATS_EN for the counter expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_prol16_mem_slave;

    localparam int DW    = 16;
    localparam int AB    = 10;
    localparam int CW    = 32;
    localparam int DEPTH = 1024;
`ifdef PROL16_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk;
    logic          rst_n;
    logic          load_valid_i;
    logic          load_ready_o;
    logic [DW-1:0] load_data_i;
    logic          load_last_i;
    logic          cpu_en_o;
    logic [DW-1:0] mem_addr_i;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_ce_ni;
    logic          mem_oe_ni;
    logic          mem_we_ni;
    logic          cpu_halt_i;
    logic          illegal_inst_i;
    logic          halted_o;
    logic          illegal_o;
    logic          bus_err_o;
    logic          load_ovf_o;
    logic [AB-1:0] dump_addr_i;
    logic [DW-1:0] dump_data_o;
    logic [CW-1:0] rd_cnt_o;
    logic [CW-1:0] wr_cnt_o;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prol16_mem_slave #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid_i   (load_valid_i),
        .load_ready_o   (load_ready_o),
        .load_data_i    (load_data_i),
        .load_last_i    (load_last_i),
        .cpu_en_o       (cpu_en_o),
        .mem_addr_i     (mem_addr_i),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ce_ni      (mem_ce_ni),
        .mem_oe_ni      (mem_oe_ni),
        .mem_we_ni      (mem_we_ni),
        .cpu_halt_i     (cpu_halt_i),
        .illegal_inst_i (illegal_inst_i),
        .halted_o       (halted_o),
        .illegal_o      (illegal_o),
        .bus_err_o      (bus_err_o),
        .load_ovf_o     (load_ovf_o),
        .dump_addr_i    (dump_addr_i),
        .dump_data_o    (dump_data_o),
        .rd_cnt_o       (rd_cnt_o),
        .wr_cnt_o       (wr_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_state;
    int            m_ptr;
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] m_rd;
    bit            m_rd_known;
    logic [DW-1:0] m_dump;
    bit            m_dump_known;
    bit            m_ill, m_err, m_ovf;
    logic [31:0]   m_rdc, m_wrc;
    bit            m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state      <= M_LOAD;
            m_ptr        <= 0;
            m_rd         <= '0;
            m_rd_known   <= 1'b1;
            m_dump       <= '0;
            m_dump_known <= 1'b1;
            m_ill        <= 1'b0;
            m_err        <= 1'b0;
            m_ovf        <= 1'b0;
            m_rdc        <= '0;
            m_wrc        <= '0;
            m_valid      <= 1'b1;
        end else begin
            m_dump       <= m_mem[dump_addr_i];
            m_dump_known <= m_known[dump_addr_i];
            if (m_state == M_LOAD) begin
                if (load_valid_i) begin
                    m_mem[m_ptr]   <= load_data_i;
                    m_known[m_ptr] <= 1'b1;
                    m_ptr          <= (m_ptr + 1) % DEPTH;
                    if (load_last_i) begin
                        m_state <= M_RUN;
                    end else if (m_ptr == DEPTH - 1) begin
                        m_state <= M_RUN;
                        m_ovf   <= 1'b1;
                    end
                end
            end else if (m_state == M_RUN) begin
                if (!mem_ce_ni) begin
                    if (!mem_oe_ni && !mem_we_ni) begin
                        m_err <= 1'b1;
                    end else if (!mem_oe_ni) begin
                        if (m_rdc != 32'hFFFF_FFFF) m_rdc <= m_rdc + 1;
                        if (int'(mem_addr_i) < DEPTH) begin
                            m_rd       <= m_mem[mem_addr_i[AB-1:0]];
                            m_rd_known <= m_known[mem_addr_i[AB-1:0]];
                        end else begin
                            m_rd       <= '0;
                            m_rd_known <= 1'b1;
                            m_err      <= 1'b1;
                        end
                    end else if (!mem_we_ni) begin
                        if (m_wrc != 32'hFFFF_FFFF) m_wrc <= m_wrc + 1;
                        if (int'(mem_addr_i) < DEPTH) begin
                            m_mem[mem_addr_i[AB-1:0]]   <= mem_data_i;
                            m_known[mem_addr_i[AB-1:0]] <= 1'b1;
                        end else begin
                            m_err <= 1'b1;
                        end
                    end
                end
                if (illegal_inst_i) m_ill <= 1'b1;
                if (cpu_halt_i || illegal_inst_i) m_state <= M_HALT;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("load_ready", {31'b0, load_ready_o}, {31'b0, m_state == M_LOAD});
            chk("cpu_en",     {31'b0, cpu_en_o},     {31'b0, m_state == M_RUN});
            chk("halted",     {31'b0, halted_o},     {31'b0, m_state == M_HALT});
            chk("illegal",    {31'b0, illegal_o},    {31'b0, m_ill});
            chk("bus_err",    {31'b0, bus_err_o},    {31'b0, m_err});
            chk("load_ovf",   {31'b0, load_ovf_o},   {31'b0, m_ovf});
            chk("rd_cnt",     rd_cnt_o, STATS ? m_rdc : 32'd0);
            chk("wr_cnt",     wr_cnt_o, STATS ? m_wrc : 32'd0);
            if (m_rd_known)   chk("mem_data",  {16'b0, mem_data_o},  {16'b0, m_rd});
            if (m_dump_known) chk("dump_data", {16'b0, dump_data_o}, {16'b0, m_dump});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit exceeded");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        load_valid_i   = 1'b0;
        load_last_i    = 1'b0;
        load_data_i    = '0;
        mem_ce_ni      = 1'b1;
        mem_oe_ni      = 1'b1;
        mem_we_ni      = 1'b1;
        cpu_halt_i     = 1'b0;
        illegal_inst_i = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DW-1:0] d, input bit last);
        load_valid_i = 1'b1;
        load_data_i  = d;
        load_last_i  = last;
        cyc(1);
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic cpu_rd(input logic [DW-1:0] a);
        mem_addr_i = a;
        mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b1;
        cyc(1);
        mem_ce_ni = 1'b1; mem_oe_ni = 1'b1; mem_we_ni = 1'b1;
    endtask

    task automatic cpu_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
        mem_addr_i = a;
        mem_data_i = d;
        mem_ce_ni = 1'b0; mem_oe_ni = 1'b1; mem_we_ni = 1'b0;
        cyc(1);
        mem_ce_ni = 1'b1; mem_oe_ni = 1'b1; mem_we_ni = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            r = $urandom_range(0, 99);
            mem_addr_i  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                                      : 16'($urandom_range(0, 31));
            mem_data_i  = 16'($urandom);
            dump_addr_i = 10'($urandom_range(0, 31));
            if (r < 30) begin
                mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b1;
            end else if (r < 60) begin
                mem_ce_ni = 1'b0; mem_oe_ni = 1'b1; mem_we_ni = 1'b0;
            end else if (r < 63) begin
                mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b0;
            end else if (r < 80) begin
                mem_ce_ni = 1'b1; mem_oe_ni = 1'($urandom); mem_we_ni = 1'($urandom);
            end else begin
                mem_ce_ni = 1'b1; mem_oe_ni = 1'b1; mem_we_ni = 1'b1;
            end
            cpu_halt_i     = ($urandom_range(0, 399) == 0);
            illegal_inst_i = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        idle();
    endtask

    // ---------------- directed plan + random sessions ----------------
    logic [DW-1:0] plan_words [4];

    initial begin
        int n;
        plan_words[0] = 16'h1111;
        plan_words[1] = 16'h2222;
        plan_words[2] = 16'h3333;
        plan_words[3] = 16'h4444;
        rst_n       = 1'b0;
        idle();
        mem_addr_i  = '0;
        mem_data_i  = '0;
        dump_addr_i = '0;
        cyc(3);
        chk("reset_load_ready", {31'b0, load_ready_o}, 32'd1);
        chk("reset_cpu_en",     {31'b0, cpu_en_o},     32'd0);
        chk("reset_halted",     {31'b0, halted_o},     32'd0);
        chk("reset_mem_data",   {16'b0, mem_data_o},   32'd0);
        chk("reset_rd_cnt",     rd_cnt_o,              32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Abort a load after two words, then reload from pointer zero.
        load(16'h1111, 1'b0);
        load(16'h2222, 1'b0);
        rst_n = 1'b0;
        cyc(1);
        chk("midload_rst_ready", {31'b0, load_ready_o}, 32'd1);
        chk("midload_rst_cpuen", {31'b0, cpu_en_o},     32'd0);
        chk("midload_rst_ovf",   {31'b0, load_ovf_o},   32'd0);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            load(plan_words[i], i == 3);
            if (i < 3) cyc($urandom_range(0, 2));
        end
        chk("plan_ready_drop", {31'b0, load_ready_o}, 32'd0);
        chk("plan_cpu_en",     {31'b0, cpu_en_o},     32'd1);
        dump_addr_i = 10'd3;
        cyc(1);
        chk("plan_dump3", {16'b0, dump_data_o}, 32'h4444);

        cpu_rd(16'd2);
        chk("plan_rd2",     {16'b0, mem_data_o}, 32'h3333);
        chk("plan_rd_cnt1", rd_cnt_o, STATS ? 32'd1 : 32'd0);

        cpu_wr(16'd1, 16'hBEEF);
        cpu_rd(16'd1);
        chk("plan_wr_rd1",  {16'b0, mem_data_o}, 32'hBEEF);
        chk("plan_wr_cnt1", wr_cnt_o, STATS ? 32'd1 : 32'd0);

        mem_addr_i = 16'd0;
        mem_data_i = 16'hDEAD;
        mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b0;
        cyc(1);
        idle();
        chk("plan_err_flag", {31'b0, bus_err_o},  32'd1);
        chk("plan_err_hold", {16'b0, mem_data_o}, 32'hBEEF);
        cpu_rd(16'd0);
        chk("plan_err_ram0", {16'b0, mem_data_o}, 32'h1111);
        cpu_rd(16'h0400);
        chk("plan_oor_rd0",  {16'b0, mem_data_o}, 32'h0000);

        illegal_inst_i = 1'b1;
        cyc(1);
        illegal_inst_i = 1'b0;
        chk("plan_halted",  {31'b0, halted_o},  32'd1);
        chk("plan_illegal", {31'b0, illegal_o}, 32'd1);
        chk("plan_halt_en", {31'b0, cpu_en_o},  32'd0);
        cpu_wr(16'd1, 16'h5555);
        dump_addr_i = 10'd1;
        cyc(1);
        chk("plan_dump1_frozen", {16'b0, dump_data_o}, 32'hBEEF);

        // Fresh session: range error on a write alone raises bus_err.
        do_reset();
        chk("s2_err_clear", {31'b0, bus_err_o}, 32'd0);
        n = $urandom_range(4, 24);
        for (int i = 0; i < n; i++) load(16'($urandom), i == n - 1);
        cpu_wr(16'h0400 + 16'($urandom_range(0, 255)), 16'h1234);
        chk("s2_oor_wr_err", {31'b0, bus_err_o}, 32'd1);
        rand_run(400);

        // Fresh session: random traffic from a clean error flag.
        do_reset();
        n = $urandom_range(8, 40);
        for (int i = 0; i < n; i++) load(16'($urandom), i == n - 1);
        rand_run(400);

        // Fill the whole memory without a last marker.
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(16'($urandom), 1'b0);
        chk("ovf_flag",   {31'b0, load_ovf_o}, 32'd1);
        chk("ovf_cpu_en", {31'b0, cpu_en_o},   32'd1);
        rand_run(200);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
